int4_vec_packer: RTL
====================

// Module: int4_vec_packer
// PURPOSE
//  Producer side of the int4 MAC operand bus. Collects a stream of signed-agnostic
//  4-bit elements plus an 8-bit scale and packs them into the 264-bit operand word
//  consumed by the int4 MAC array. Nibbles 0-1 carry the scale, nibbles 2..64 carry
//  63 elements, and nibble 65 is zero.
//  Sits between the operand SRAM/quantizer stream and the MAC operand registers.
// PARAMETERS
//  LANES  1  elements accepted per input beat; legal values 1,3,7,9,21,63 (divide 63)
// PORTS
//  clk           input   1          rising-edge clock
//  rst_n         input   1          asynchronous active-low reset
//  in_valid      input   1          input beat valid
//  in_ready      output  1          packer can accept a beat
//  in_elem       input   4*LANES    elements; lane i at bits [4*i +: 4]
//  in_scale      input   8          scale; sampled only on first beat of a block
//  in_last       input   1          final beat of block; remaining slots zero-filled
//  out_valid     output  1          out_vec holds a complete packed word
//  out_ready     input   1          consumer accepts out_vec
//  out_vec       output  264        packed operand word
//  out_nelem     output  6          number of valid elements in out_vec (1..63)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, elem counter=0, out_vec=0, out_nelem=0,
//   out_valid=0, in_ready=0 while rst_n=0. in_ready=1 from first clk after release.
//   A block in flight at reset is discarded; no partial output is emitted.
//  Beat accepted when in_valid & in_ready at posedge.
//  States:
//   IDLE : counter=0. Accepted beat -> latch in_scale into out_vec[7:0]; go FILL
//          (or FULL if beat completes block).
//   FILL : each accepted beat writes its LANES elements. Go FULL when counter
//          reaches 63 or in_last is set on the beat.
//   FULL : out_valid=1, in_ready=0; out_vec/out_nelem stable until out_ready=1.
//          On handshake -> IDLE, vector register cleared to 0.
//  in_ready = (state != FULL). There is no same-cycle bypass: a beat presented while
//   FULL is not accepted even if out_ready=1 that cycle.
//  Placement: element k (0..62, counted from block start; lane i of a beat lands at
//   k=counter+i) -> out_vec[(k+2)*4 +: 4]. in_scale[3:0] -> nibble 0,
//   in_scale[7:4] -> nibble 1. out_vec[263:260] is always 0.
//  Latency: out_valid rises on the cycle after the completing beat is accepted.
//   Max throughput is one word per 63/LANES + 1 cycles.
//  in_last: unwritten slots stay 0 (zero elements contribute nothing to the MAC).
//   out_nelem = counter after the last beat.
//  Counter never exceeds 63: LANES divides 63, so a block auto-completes on its
//   63rd element and in_last on that beat is redundant but legal.
//  A block is never split across outputs; scale is never re-sampled mid-block.
//  in_elem/in_scale are don't-care when in_valid=0 or in_ready=0.
// TESTING
//  T1 LANES=1: 63 beats elem=k[3:0], scale=8'hA5, out_ready=1 -> 1 cycle after beat
//     63, out_valid=1, out_vec[7:0]=A5, nibble k+2 = k%16, out_vec[263:260]=0,
//     out_nelem=63.
//  T2 In-last: 5 beats elem=4'hF with in_last on beat 5 -> out_nelem=5, nibbles 2..6=F,
//     out_vec[263:28]=0.
//  T3 Backpressure: out_ready=0 for 10 cycles after FULL -> out_valid and out_vec stable,
//     in_ready=0, next-block beats are not accepted. out_ready=1 -> in_ready=1 the
//     next cycle.
//  T4 Reset mid-block: assert rst_n=0 asynchronously after 20 beats -> out_valid=0 and
//     out_vec=0 immediately. A fresh 63-beat block then packs correctly with no
//     stale elements.
//  T5 LANES=3: 21 beats lanes {3k,3k+1,3k+2} -> same packing as T1; out_valid after
//     beat 21.
//  T6 Back-to-back: two blocks with in_valid held high and out_ready=1 -> second block
//     carries its own scale; the first beat of block 2 is accepted the cycle after the
//     block-1 output handshake.

Source files
------------

// File: rtl/int4_vec_packer.sv
// -----------------------------------------------------------------------------
// int4_vec_packer
//
// Producer side of the int4 MAC operand bus. Collects a stream of 4-bit
// elements (LANES per beat) plus an 8-bit scale and packs one block of up to
// 63 elements into a 264-bit operand word for the int4 MAC array.
//
// Word layout:
//   nibbles 0-1   : scale (in_scale[3:0] -> nibble 0, in_scale[7:4] -> nibble 1)
//   nibbles 2..64 : elements 0..62 of the block
//   nibble 65     : always zero
//
// Parameters:
//   LANES      elements per input beat; must divide 63 (1,3,7,9,21,63)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   packer can accept a beat
//   in_elem    LANES elements, lane i at bits [4*i +: 4]
//   in_scale   block scale, sampled only on the first beat of a block
//   in_last    final beat of the block; remaining slots stay zero
//   out_valid  out_vec holds a complete packed word
//   out_ready  consumer accepts out_vec
//   out_vec    packed operand word
//   out_nelem  number of valid elements in out_vec (1..63)
// -----------------------------------------------------------------------------
module int4_vec_packer #(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*LANES-1:0] in_elem,
    input  logic [7:0]         in_scale,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [263:0]       out_vec,
    output logic [5:0]         out_nelem
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

    localparam int MAX_ELEMS = 63;

    state_t         state_q;
    state_t         state_d;
    logic [5:0]     count_q;
    logic [6:0]     count_sum;
    logic [263:0]   vec_q;
    logic           ready_en_q;
    logic           accept;
    logic           block_done;
    logic           handshake;

    // in_ready must stay low while reset is held and only rise on the first
    // clock after release, so it is qualified by a flop that reset clears.
    assign in_ready   = ready_en_q && (state_q != FULL);
    assign accept     = in_valid && in_ready;
    assign handshake  = (state_q == FULL) && out_ready;

    // Because LANES divides 63 the running count lands exactly on 63 when a
    // block fills up; it can never step past it.
    assign count_sum  = {1'b0, count_q} + 7'(LANES);
    assign block_done = accept && ((count_sum == 7'(MAX_ELEMS)) || in_last);

    assign out_valid  = (state_q == FULL);
    assign out_vec    = vec_q;
    assign out_nelem  = (state_q == FULL) ? count_q : 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = block_done ? FULL : FILL;
                end
            end
            FILL: begin
                if (block_done) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: the word register is cleared after each handshake so slots
    // left unwritten by an early in_last read back as zero elements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (handshake) begin
                vec_q   <= '0;
                count_q <= '0;
            end else if (accept) begin
                // Scale is captured only at block start, never mid-block.
                if (state_q == IDLE) begin
                    vec_q[7:0] <= in_scale;
                end
                for (int i = 0; i < LANES; i++) begin
                    vec_q[(int'(count_q) + i + 2) * 4 +: 4] <= in_elem[4*i +: 4];
                end
                count_q <= count_sum[5:0];
            end
        end
    end

endmodule
